lsu_mem_master: RTL and testbench
=================================

// Module: lsu_mem_master
// PURPOSE
//  Core-side load/store unit; initiator for the word-addressed data memory port
//  (mem_req/write_enable/addr/write_data/read_data).
//  Converts RV32I byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses:
//  - lane extraction and sign/zero extension on loads
//  - read-modify-write for sub-word stores
//  Stalls the core for the duration of each access.
// PARAMETERS
//  MEM_WORDS  1024  words in target memory; word index >= MEM_WORDS is an access error
// PORTS
//  clk_i         in   1   clock, all state updates on rising edge
//  rst_i         in   1   synchronous reset, active-high
//  core_req_i    in   1   core requests an access; held with operands until stall drops
//  core_we_i     in   1   1 = store, 0 = load
//  core_size_i   in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  core_addr_i   in   32  byte address
//  core_wd_i     in   32  store data (low lanes used for B/H)
//  core_rd_o     out  32  load result, valid only in DONE
//  core_stall_o  out  1   1 while an accepted/pending request is not yet complete
//  err_o         out  1   misaligned, illegal size or out-of-range; valid only in DONE
//  mem_req_o     out  1   memory request
//  mem_we_o      out  1   memory write enable
//  mem_addr_o    out  32  word index = {2'b00, addr[31:2]}
//  mem_wd_o      out  32  full word to write
//  mem_rd_i      in   32  combinational read data from memory
// BEHAVIOUR
//  Reset: state=IDLE; all regs 0; core_rd_o=0, err_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wd_o=0.
//  FSM: IDLE, RD, WR, RMW_RD, RMW_WR, DONE.
//  IDLE: on core_req_i latch we/size/addr/wd; classify the request.
//  Error if any of:
//   - H/HU/SH with addr[0]=1
//   - W with addr[1:0]!=0
//   - size 011/110/111
//   - store with size 100/101
//   - addr[31:2] >= MEM_WORDS
//  IDLE transitions:
//   - error -> DONE; no memory access
//   - load -> RD
//   - SW -> WR
//   - SB/SH -> RMW_RD
//  RD: mem_req=1, we=0; capture extracted result -> DONE.
//  WR: mem_req=1, we=1, wd=store data -> DONE.
//  RMW_RD: mem_req=1, we=0; capture mem_rd_i into merge reg -> RMW_WR.
//  RMW_WR: mem_req=1, we=1, wd=merged word -> DONE.
//  DONE: stall=0; core_rd_o/err_o valid this cycle only -> IDLE.
//   - core_rd_o=0 for stores and on error.
//  core_stall_o = (state==IDLE & core_req_i) | (state!=IDLE & state!=DONE).
//  Latency, cycles from accept to DONE inclusive:
//   - load/SW: 3 (stall 2)
//   - SB/SH: 4 (stall 3)
//   - error: 2 (stall 1)
//  Next request is accepted in the IDLE cycle following DONE.
//  mem outputs are decoded from state and latched regs only; no core input feeds mem ports.
//  mem_req_o=0 in IDLE and DONE.
//  Exactly one mem_we_o pulse per store; none for loads or errors.
//  Load extract: byte = word >> 8*addr[1:0]; half = word >> 16*addr[1];
//   - LB/LH sign-extend; LBU/LHU zero-extend
//  Store merge: SB replaces lane addr[1:0] with wd[7:0]; SH replaces half addr[1] with wd[15:0].
//   - other lanes preserved from the RMW_RD read
//  rst_i wins over every transition: state -> IDLE at that edge.
//   - a store reset before its write cycle is never written; memory unchanged
// TESTING
//  mem[5]=0x8899AABB; LB 0x16 -> rd=0xFFFFFF99; LBU 0x16 -> 0x00000099; LHU 0x16 -> 0x00008899.
//  SB 0x15 wd=0x12345677 -> mem[5]=0x889977BB; one read pulse then one write pulse; stall 3 cycles.
//  SW 0x14 wd=0xDEADBEEF, then LH 0x16 -> mem[5]=0xDEADBEEF, rd=0xFFFFDEAD; stall 2 cycles each.
//  Error cases -> err_o=1 in DONE, rd=0, mem_req_o never asserted, stall 1 cycle:
//   - LW 0x13
//   - SH 0x11
//   - LW 0x1000 (word 1024, MEM_WORDS=1024)
//  SB 0x14 with rst_i=1 at edge leaving RMW_RD -> IDLE next; mem[5] unchanged; no mem_we_o pulse.
//  core_req_i held high across two back-to-back LWs -> second accepted the cycle after first DONE.

Source files
------------

// File: rtl/lsu_mem_master_if.sv
// Word-addressed data memory port between the load/store unit and memory.
// Read data is combinational from mem_addr.
interface lsu_mem_master_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wd,
    input  mem_rd
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/lsu_mem_master.sv
// RV32I load/store unit: turns byte-addressed B/H/W requests into word accesses,
// with lane extraction on loads and read-modify-write for sub-word stores.
module lsu_mem_master #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     core_req_i,
  input  logic                     core_we_i,
  input  logic [2:0]               core_size_i,
  input  logic [31:0]              core_addr_i,
  input  logic [31:0]              core_wd_i,
  output logic [31:0]              core_rd_o,
  output logic                     core_stall_o,
  output logic                     err_o,
  lsu_mem_master_if.master         mem
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_DONE
  } state_t;

  state_t      state_q, state_d;

  logic        we_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wd_q;
  logic [31:0] merge_q;
  logic [31:0] rd_q;
  logic        err_q;

  logic        size_bad;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;

  function automatic logic [31:0] load_extract(
    input logic [31:0] word,
    input logic [2:0]  size,
    input logic [1:0]  off
  );
    logic [31:0] shifted;
    logic [31:0] res;
    shifted = word >> {off, 3'b000};
    case (size[1:0])
      2'b00:   res = {{24{shifted[7]  & ~size[2]}}, shifted[7:0]};
      2'b01:   res = {{16{shifted[15] & ~size[2]}}, shifted[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] store_merge(
    input logic [31:0] word,
    input logic [31:0] wd,
    input logic        is_half,
    input logic [1:0]  off
  );
    logic [31:0] res;
    res = word;
    if (is_half) begin
      if (off[1]) res[31:16] = wd[15:0];
      else        res[15:0]  = wd[15:0];
    end else begin
      case (off)
        2'd0:    res[7:0]   = wd[7:0];
        2'd1:    res[15:8]  = wd[7:0];
        2'd2:    res[23:16] = wd[7:0];
        default: res[31:24] = wd[7:0];
      endcase
    end
    return res;
  endfunction

  // Classification looks at the live core inputs; it only matters in the accept cycle.
  always_comb begin
    size_bad     = (core_size_i == 3'b011) || (core_size_i == 3'b110) ||
                   (core_size_i == 3'b111) || (core_we_i && core_size_i[2]);
    misaligned   = ((core_size_i[1:0] == 2'b01) && core_addr_i[0]) ||
                   ((core_size_i == 3'b010) && (core_addr_i[1:0] != 2'b00));
    out_of_range = ({2'b00, core_addr_i[31:2]} >= MEM_WORDS);
    req_err      = size_bad || misaligned || out_of_range;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (core_req_i) begin
          if (req_err)                     state_d = S_DONE;
          else if (!core_we_i)             state_d = S_RD;
          else if (core_size_i == 3'b010)  state_d = S_WR;
          else                             state_d = S_RMW_RD;
        end
      end
      S_RD:     state_d = S_DONE;
      S_WR:     state_d = S_DONE;
      S_RMW_RD: state_d = S_RMW_WR;
      S_RMW_WR: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      merge_q <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (core_req_i) begin
            we_q   <= core_we_i;
            size_q <= core_size_i;
            addr_q <= core_addr_i;
            wd_q   <= core_wd_i;
            err_q  <= req_err;
            rd_q   <= '0;
          end
        end
        S_RD:     rd_q    <= load_extract(mem.mem_rd, size_q, addr_q[1:0]);
        S_RMW_RD: merge_q <= store_merge(mem.mem_rd, wd_q, size_q[0], addr_q[1:0]);
        default: ;
      endcase
    end
  end

  // Memory-side outputs depend only on state and latched operands.
  always_comb begin
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.mem_addr = '0;
    mem.mem_wd   = '0;
    case (state_q)
      S_RD, S_RMW_RD: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = {2'b00, addr_q[31:2]};
      end
      S_WR: begin
        mem.mem_req  = 1'b1;
        mem.mem_we   = 1'b1;
        mem.mem_addr = {2'b00, addr_q[31:2]};
        mem.mem_wd   = wd_q;
      end
      S_RMW_WR: begin
        mem.mem_req  = 1'b1;
        mem.mem_we   = 1'b1;
        mem.mem_addr = {2'b00, addr_q[31:2]};
        mem.mem_wd   = merge_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    core_stall_o = ((state_q == S_IDLE) && core_req_i) ||
                   ((state_q != S_IDLE) && (state_q != S_DONE));
    core_rd_o    = '0;
    err_o        = 1'b0;
    if (state_q == S_DONE) begin
      core_rd_o = (we_q || err_q) ? '0 : rd_q;
      err_o     = err_q;
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: directed vector table, hand-written corner sequences,
// and randomized accesses checked against a byte-lane reference model.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req;
  logic        core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr;
  logic [31:0] core_wd;
  logic [31:0] core_rd;
  logic        core_stall;
  logic        err;

  lsu_mem_master_if mif();

  lsu_mem_master #(.MEM_WORDS(1024)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .core_req_i   (core_req),
    .core_we_i    (core_we),
    .core_size_i  (core_size),
    .core_addr_i  (core_addr),
    .core_wd_i    (core_wd),
    .core_rd_o    (core_rd),
    .core_stall_o (core_stall),
    .err_o        (err),
    .mem          (mif)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];

  assign mif.mem_rd = mem[mif.mem_addr[9:0]];

  always @(posedge clk) begin
    if (mif.mem_req && mif.mem_we) mem[mif.mem_addr[9:0]] <= mif.mem_wd;
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: byte-lane arithmetic over a word array; also updates ref_mem for stores.
  task automatic model(input logic we, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic e,
                       output int stall, output int rds, output int wrs);
    int unsigned widx, off, sz;
    logic [31:0] word, lanes, mask, data;
    widx = addr / 4;
    off  = addr % 4;
    sz   = size;
    e = (sz == 3 || sz == 6 || sz == 7) || (we && sz >= 4) ||
        ((sz % 4 == 1) && (addr % 2 == 1)) || (sz == 2 && off != 0) || (widx >= 1024);
    rd = 0; stall = 1; rds = 0; wrs = 0;
    if (!e) begin
      word = ref_mem[widx];
      if (!we) begin
        stall = 2; rds = 1;
        if (sz % 4 == 0) begin
          lanes = (word / (32'd1 << (8 * off))) % 256;
          rd = (sz == 0 && lanes >= 128) ? lanes - 32'd256 : lanes;
        end else if (sz % 4 == 1) begin
          lanes = (word / (32'd1 << (16 * (off / 2)))) % 65536;
          rd = (sz == 1 && lanes >= 32768) ? lanes - 32'd65536 : lanes;
        end else rd = word;
      end else if (sz == 2) begin
        stall = 2; wrs = 1;
        ref_mem[widx] = wd;
      end else begin
        stall = 3; rds = 1; wrs = 1;
        if (sz == 0) begin
          mask = 32'hFF << (8 * off);
          data = (wd % 256) << (8 * off);
        end else begin
          mask = 32'hFFFF << (16 * (off / 2));
          data = (wd % 65536) << (16 * (off / 2));
        end
        ref_mem[widx] = (word & ~mask) | data;
      end
    end
  endtask

  // Drive one request in an IDLE cycle, hold it until the DONE cycle, then drop it.
  task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic e,
                        output int stall, output int rds, output int wrs,
                        output logic done_req);
    bit done;
    core_req = 1'b1; core_we = we; core_size = size; core_addr = addr; core_wd = wd;
    stall = 0; rds = 0; wrs = 0; done = 0; rd = 'x; e = 1'bx; done_req = 1'bx;
    for (int c = 0; c < 12 && !done; c++) begin
      @(negedge clk);
      if (mif.mem_req) begin
        if (mif.mem_we) wrs++;
        else            rds++;
      end
      if (core_stall) stall++;
      else begin
        done = 1; rd = core_rd; e = err; done_req = mif.mem_req;
      end
    end
    if (!done) check("access timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    core_req = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_stall;
    int          exp_rds;
    int          exp_wrs;
    logic [31:0] exp_mem5;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [31:0] rd, mrd;
    logic        e, me, dreq;
    int          st, rds, wrs, mst, mrds, mwrs;

    for (int i = 0; i < 1024; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    mem[5] = 32'h8899AABB; ref_mem[5] = 32'h8899AABB;

    tbl[0]  = '{1'b0, 3'b000, 32'h16,   32'h0,        32'hFFFFFF99, 1'b0, 2, 1, 0, 32'h8899AABB};
    tbl[1]  = '{1'b0, 3'b100, 32'h16,   32'h0,        32'h00000099, 1'b0, 2, 1, 0, 32'h8899AABB};
    tbl[2]  = '{1'b0, 3'b101, 32'h16,   32'h0,        32'h00008899, 1'b0, 2, 1, 0, 32'h8899AABB};
    tbl[3]  = '{1'b1, 3'b000, 32'h15,   32'h12345677, 32'h0,        1'b0, 3, 1, 1, 32'h889977BB};
    tbl[4]  = '{1'b1, 3'b010, 32'h14,   32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1, 32'hDEADBEEF};
    tbl[5]  = '{1'b0, 3'b001, 32'h16,   32'h0,        32'hFFFFDEAD, 1'b0, 2, 1, 0, 32'hDEADBEEF};
    tbl[6]  = '{1'b0, 3'b010, 32'h13,   32'h0,        32'h0,        1'b1, 1, 0, 0, 32'hDEADBEEF};
    tbl[7]  = '{1'b1, 3'b001, 32'h11,   32'hFFFF,     32'h0,        1'b1, 1, 0, 0, 32'hDEADBEEF};
    tbl[8]  = '{1'b0, 3'b010, 32'h1000, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'hDEADBEEF};
    tbl[9]  = '{1'b0, 3'b011, 32'h14,   32'h0,        32'h0,        1'b1, 1, 0, 0, 32'hDEADBEEF};
    tbl[10] = '{1'b1, 3'b101, 32'h14,   32'h1234,     32'h0,        1'b1, 1, 0, 0, 32'hDEADBEEF};
    tbl[11] = '{1'b1, 3'b010, 32'hFFC,  32'hCAFEF00D, 32'h0,        1'b0, 2, 0, 1, 32'hDEADBEEF};
    tbl[12] = '{1'b0, 3'b010, 32'hFFC,  32'h0,        32'hCAFEF00D, 1'b0, 2, 1, 0, 32'hDEADBEEF};

    rst = 1'b1; core_req = 1'b0; core_we = 1'b0; core_size = '0; core_addr = '0; core_wd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset rd",    core_rd, 32'd0);
    check("reset err",   {31'd0, err}, 32'd0);
    check("reset stall", {31'd0, core_stall}, 32'd0);
    check("reset mem_req/we", {30'd0, mif.mem_req, mif.mem_we}, 32'd0);
    check("reset mem_addr", mif.mem_addr, 32'd0);
    check("reset mem_wd",   mif.mem_wd, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      model(tbl[i].we, tbl[i].size, tbl[i].addr, tbl[i].wd, mrd, me, mst, mrds, mwrs);
      access(tbl[i].we, tbl[i].size, tbl[i].addr, tbl[i].wd, rd, e, st, rds, wrs, dreq);
      check($sformatf("tbl%0d rd", i),    rd, tbl[i].exp_rd);
      check($sformatf("tbl%0d err", i),   {31'd0, e}, {31'd0, tbl[i].exp_err});
      check($sformatf("tbl%0d stall", i), st, tbl[i].exp_stall);
      check($sformatf("tbl%0d reads", i), rds, tbl[i].exp_rds);
      check($sformatf("tbl%0d writes", i), wrs, tbl[i].exp_wrs);
      check($sformatf("tbl%0d done mem_req", i), {31'd0, dreq}, 32'd0);
      check($sformatf("tbl%0d mem5", i),  mem[5], tbl[i].exp_mem5);
    end

    // SB reset at the edge leaving RMW_RD: the write must never happen.
    wrs = 0;
    core_req = 1'b1; core_we = 1'b1; core_size = 3'b000; core_addr = 32'h14; core_wd = 32'h55;
    @(posedge clk); #1;
    core_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    if (mif.mem_req && mif.mem_we) wrs++;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mif.mem_req && mif.mem_we) wrs++;
      if (c == 0) check("rst-rmw idle stall", {31'd0, core_stall}, 32'd0);
      if (c == 0) check("rst-rmw idle mem_req", {31'd0, mif.mem_req}, 32'd0);
    end
    check("rst-rmw writes", wrs, 0);
    check("rst-rmw mem5", mem[5], 32'hDEADBEEF);
    @(posedge clk); #1;

    // Back-to-back LW with core_req held through DONE.
    core_req = 1'b1; core_we = 1'b0; core_size = 3'b010; core_addr = 32'h14; core_wd = '0;
    begin
      bit done;
      for (int k = 0; k < 2; k++) begin
        done = 0; st = 0;
        for (int c = 0; c < 12 && !done; c++) begin
          @(negedge clk);
          if (core_stall) st++;
          else begin done = 1; rd = core_rd; end
        end
        if (!done) check("b2b timeout", 32'd0, 32'd1);
        check($sformatf("b2b%0d stall", k), st, 2);
        check($sformatf("b2b%0d rd", k), rd, 32'hDEADBEEF);
        @(posedge clk); #1;
      end
    end
    core_req = 1'b0;

    for (int i = 0; i < 300; i++) begin
      logic        rwe;
      logic [2:0]  rsz;
      logic [31:0] raddr, rwd;
      int unsigned widx;
      rwe = 1'($urandom_range(0, 1));
      rsz = 3'($urandom_range(0, 7));
      rwd = $urandom;
      if ($urandom_range(0, 9) == 0) raddr = $urandom;
      else if ($urandom_range(0, 9) == 0) raddr = 32'hFFC + 32'($urandom_range(0, 7));
      else raddr = 32'($urandom_range(0, 31));
      widx = raddr / 4;
      model(rwe, rsz, raddr, rwd, mrd, me, mst, mrds, mwrs);
      access(rwe, rsz, raddr, rwd, rd, e, st, rds, wrs, dreq);
      check($sformatf("rnd%0d rd", i),     rd, mrd);
      check($sformatf("rnd%0d err", i),    {31'd0, e}, {31'd0, me});
      check($sformatf("rnd%0d stall", i),  st, mst);
      check($sformatf("rnd%0d reads", i),  rds, mrds);
      check($sformatf("rnd%0d writes", i), wrs, mwrs);
      if (widx < 1024) check($sformatf("rnd%0d mem", i), mem[widx], ref_mem[widx]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
